// File: rtl/position_ring_scheduler_if.sv
// -----------------------------------------------------------------------------
// position_ring_scheduler_if
//
// Purpose : bundles the run-control and ring-node signals of the position ring
//           scheduler. Signal prefixes are from the scheduler's point of view:
//           i_* flow into the scheduler, o_* flow out of it.
//
// Parameters:
//   NNODES - number of ring nodes (width of the done vectors)
//   TSW    - width of the timestep count / counter
//
// Signals:
//   i_start          run-control start pulse
//   i_num_timesteps  timesteps to run (latched on start)
//   i_done_batch_vec per-node done_batch
//   i_done_all_vec   per-node done_all
//   o_dispatch       node command: 00 run, 01 start batch, 11 clear
//   o_double_buffer  BRAM half select broadcast to the nodes
//   o_busy           scheduler is not idle
//   o_batch_count    batches dispatched in the current timestep
//   o_timestep       completed timesteps
//   o_step_done      one-cycle pulse per completed timestep
//   o_run_done       one-cycle pulse when the final timestep completes
//   o_err            watchdog error flag
//
// Modports:
//   master - run control + ring side (drives i_*, observes o_*)
//   slave  - the scheduler itself
// -----------------------------------------------------------------------------
interface position_ring_scheduler_if #(
   parameter int NNODES = 8,
   parameter int TSW    = 16
);
   logic              i_start;
   logic [TSW-1:0]    i_num_timesteps;
   logic [NNODES-1:0] i_done_batch_vec;
   logic [NNODES-1:0] i_done_all_vec;
   logic [1:0]        o_dispatch;
   logic              o_double_buffer;
   logic              o_busy;
   logic [15:0]       o_batch_count;
   logic [TSW-1:0]    o_timestep;
   logic              o_step_done;
   logic              o_run_done;
   logic              o_err;

   modport master (
      output i_start, i_num_timesteps, i_done_batch_vec, i_done_all_vec,
      input  o_dispatch, o_double_buffer, o_busy, o_batch_count,
             o_timestep, o_step_done, o_run_done, o_err
   );

   modport slave (
      input  i_start, i_num_timesteps, i_done_batch_vec, i_done_all_vec,
      output o_dispatch, o_double_buffer, o_busy, o_batch_count,
             o_timestep, o_step_done, o_run_done, o_err
   );
endinterface

// File: rtl/position_ring_scheduler.sv
// -----------------------------------------------------------------------------
// position_ring_scheduler
//
// Purpose : sequences a ring of NNODES position ring nodes through cell-list
//           batches and timesteps. Each timestep is: CLEAR, then repeated
//           DISPATCH -> RUN -> DRAIN batches until every node reports done_all,
//           then STEP (flip the double buffer, count the timestep). The run
//           ends when the latched timestep count is reached.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  synchronous active-low reset
//   bus      position_ring_scheduler_if.slave (see interface header)
//
// Parameters:
//   NNODES       ring nodes / done vector width
//   DRAIN_CYCLES idle cycles after the last done_batch (must be >= 1)
//   TSW          timestep counter width
//   TIMEOUT      RUN-state cycle limit (watchdog build only)
//
// Build option:
//   POSITION_RING_SCHED_WATCHDOG_EN - when defined, a RUN cycle counter aborts
//   the run after TIMEOUT cycles: err set, one dispatch=11, back to IDLE with
//   no step/run pulses. When undefined err is tied low and RUN waits forever.
//
// All outputs are registered; dispatch always reflects the state entered on
// the same clock edge.
// -----------------------------------------------------------------------------
module position_ring_scheduler #(
   parameter int NNODES       = 8,
   parameter int DRAIN_CYCLES = 8,
   parameter int TSW          = 16,
   parameter int TIMEOUT      = 4096
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   position_ring_scheduler_if.slave       bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_DISPATCH,
      S_RUN,
      S_DRAIN,
      S_STEP
   } state_t;

   localparam logic [1:0] DISP_RUN   = 2'b00;
   localparam logic [1:0] DISP_BATCH = 2'b01;
   localparam logic [1:0] DISP_CLEAR = 2'b11;

   localparam int            DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

   // Elaboration-time guard: a zero drain or timeout has no meaning here.
   if (DRAIN_CYCLES < 1 || TIMEOUT < 1) begin : g_param_chk
      $error("position_ring_scheduler: DRAIN_CYCLES and TIMEOUT must be >= 1");
   end

   state_t           r_state;
   logic [1:0]       r_dispatch;
   logic             r_dbuf;
   logic             r_busy;
   logic [15:0]      r_batch_count;
   logic [TSW-1:0]   r_timestep;
   logic [TSW-1:0]   r_num;
   logic             r_step_done;
   logic             r_run_done;
   logic             r_run_first;
   logic [DCW-1:0]   r_drain_cnt;

   logic             w_all_batch;
   logic             w_all_done;
   logic [TSW-1:0]   w_ts_next;
   logic [15:0]      w_bc_next;

`ifdef POSITION_RING_SCHED_WATCHDOG_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0]   r_wd_cnt;
   logic             r_err;
`endif

   assign w_all_batch = &bus.i_done_batch_vec;
   assign w_all_done  = &bus.i_done_all_vec;
   assign w_ts_next   = r_timestep + 1'b1;
   // batch_count saturates rather than wrapping
   assign w_bc_next   = (&r_batch_count) ? r_batch_count : r_batch_count + 16'd1;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state       <= S_IDLE;
         r_dispatch    <= DISP_RUN;
         r_dbuf        <= 1'b0;
         r_busy        <= 1'b0;
         r_batch_count <= '0;
         r_timestep    <= '0;
         r_num         <= '0;
         r_step_done   <= 1'b0;
         r_run_done    <= 1'b0;
         r_run_first   <= 1'b0;
         r_drain_cnt   <= '0;
`ifdef POSITION_RING_SCHED_WATCHDOG_EN
         r_wd_cnt      <= '0;
         r_err         <= 1'b0;
`endif
      end else begin
         // pulses default low; only the DRAIN->STEP transition raises them
         r_step_done <= 1'b0;
         r_run_done  <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_dispatch <= DISP_RUN;
               r_busy     <= 1'b0;
               if (bus.i_start) begin
                  r_num         <= (bus.i_num_timesteps == '0) ? TSW'(1) : bus.i_num_timesteps;
                  r_timestep    <= '0;
                  r_batch_count <= '0;
                  r_dispatch    <= DISP_CLEAR;
                  r_busy        <= 1'b1;
                  r_state       <= S_CLEAR;
`ifdef POSITION_RING_SCHED_WATCHDOG_EN
                  r_err         <= 1'b0;
`endif
               end
            end

            S_CLEAR: begin
               r_dispatch    <= DISP_BATCH;
               r_batch_count <= w_bc_next;
               r_state       <= S_DISPATCH;
            end

            S_DISPATCH: begin
               r_dispatch  <= DISP_RUN;
               r_run_first <= 1'b1;
               r_state     <= S_RUN;
`ifdef POSITION_RING_SCHED_WATCHDOG_EN
               r_wd_cnt    <= WDW'(1);
`endif
            end

            S_RUN: begin
               // The first RUN cycle may still see done_batch from the last
               // batch (nodes have not yet reacted to dispatch), so skip it.
               r_run_first <= 1'b0;
               if (!r_run_first && w_all_batch) begin
                  r_drain_cnt <= DRAIN_LOAD;
                  r_state     <= S_DRAIN;
               end
`ifdef POSITION_RING_SCHED_WATCHDOG_EN
               else if (r_wd_cnt >= WDW'(TIMEOUT)) begin
                  r_err      <= 1'b1;
                  r_dispatch <= DISP_CLEAR;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
               end
`endif
            end

            S_DRAIN: begin
               if (r_drain_cnt != '0) begin
                  r_drain_cnt <= r_drain_cnt - 1'b1;
               end else if (w_all_done) begin
                  r_dbuf      <= ~r_dbuf;
                  r_timestep  <= w_ts_next;
                  r_step_done <= 1'b1;
                  r_run_done  <= (w_ts_next == r_num);
                  r_state     <= S_STEP;
               end else begin
                  r_dispatch    <= DISP_BATCH;
                  r_batch_count <= w_bc_next;
                  r_state       <= S_DISPATCH;
               end
            end

            S_STEP: begin
               // r_run_done holds the "last timestep" decision made on entry
               if (r_run_done) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_dispatch    <= DISP_CLEAR;
                  r_batch_count <= '0;
                  r_state       <= S_CLEAR;
               end
            end

            default: begin
               r_dispatch <= DISP_RUN;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_dispatch      = r_dispatch;
   assign bus.o_double_buffer = r_dbuf;
   assign bus.o_busy          = r_busy;
   assign bus.o_batch_count   = r_batch_count;
   assign bus.o_timestep      = r_timestep;
   assign bus.o_step_done     = r_step_done;
   assign bus.o_run_done      = r_run_done;
`ifdef POSITION_RING_SCHED_WATCHDOG_EN
   assign bus.o_err           = r_err;
`else
   assign bus.o_err           = 1'b0;
`endif

endmodule

// File: tb/tb_position_ring_scheduler.sv
// -----------------------------------------------------------------------------
// tb_position_ring_scheduler
//
// Bench for position_ring_scheduler. The stimulus process plays the ring of
// nodes with randomized batch lengths, batch counts and partial done vectors.
// Before each run it derives, from the batch plan alone, the list of visible
// events (clear, dispatch, step) with their cycle numbers and output values
// and queues them. A separate monitor pops and compares an entry every time
// the design shows dispatch!=00 or a step/run pulse.
// -----------------------------------------------------------------------------
module tb_position_ring_scheduler;

   localparam int NN  = 8;
   localparam int DR  = 8;
   localparam int TSW = 16;
   localparam int TO  = 16;

   localparam int EV_CLR = 0;
   localparam int EV_DSP = 1;
   localparam int EV_STP = 2;

   typedef struct {
      int kind;
      int cyc;
      int bc;   // -1: not checked
      int ts;
      int db;
      int rd;
   } ev_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   position_ring_scheduler_if #(.NNODES(NN), .TSW(TSW)) bus ();

   position_ring_scheduler #(
      .NNODES(NN), .DRAIN_CYCLES(DR), .TSW(TSW), .TIMEOUT(TO)
   ) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   int  cyc   = 0;
   int  n_chk = 0;
   int  n_err = 0;
   ev_t exp_q[$];
   bit  mdl_db = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [NN-1:0] partial_vec();
      logic [NN-1:0] v;
      v = NN'($urandom);
      v[$urandom_range(NN-1, 0)] = 1'b0;
      return v;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   ev_t mon_e;
   int  mon_k;
   always @(negedge clk) begin
      if (reset && (bus.o_step_done || bus.o_run_done || bus.o_dispatch != 2'b00)) begin
         mon_k = bus.o_step_done ? EV_STP :
                 (bus.o_dispatch == 2'b11) ? EV_CLR :
                 (bus.o_dispatch == 2'b01) ? EV_DSP : -1;
         if (exp_q.size() == 0) begin
            chk("unexpected_event", mon_k, -1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("event_kind", mon_k, mon_e.kind);
            chk("event_cycle", cyc, mon_e.cyc);
            if (mon_e.bc >= 0) chk("batch_count", bus.o_batch_count, mon_e.bc);
            chk("timestep", bus.o_timestep, mon_e.ts);
            chk("double_buffer", bus.o_double_buffer, mon_e.db);
            chk("run_done", bus.o_run_done, mon_e.rd);
         end
      end
   end

   // Wait (bounded) for dispatch=01 at a negedge. Returns 0 on timeout.
   task automatic wait_dispatch(output bit ok);
      int w;
      w = 0;
      while (bus.o_dispatch != 2'b01 && w < 400) begin
         @(negedge clk);
         w++;
      end
      ok = (w < 400);
      if (!ok) chk("dispatch_wait_timeout", 0, 1);
   endtask

   // One run: nts timesteps; fix_nb>0 forces batches per timestep;
   // long_d>0 forces the first batch's done_batch delay.
   task automatic run_scen(input int nts, input int fix_nb, input int long_d);
      int neff, cd, endc, nb, d, kmax;
      int dq[$];
      int lq[$];
      bit ok, inj;
      neff = (nts == 0) ? 1 : nts;
      exp_q.push_back('{EV_CLR, cyc + 1, 0, 0, mdl_db, 0});
      cd = cyc + 2;
      for (int t = 0; t < neff; t++) begin
         nb = (fix_nb > 0) ? fix_nb : $urandom_range(1, 3);
         for (int b = 0; b < nb; b++) begin
            d = (long_d > 0 && t == 0 && b == 0) ? long_d : $urandom_range(1, 6);
            exp_q.push_back('{EV_DSP, cd, b + 1, t, mdl_db, 0});
            // dispatch + RUN (at least 2, first ignored) + drain
            endc = cd + 1 + ((d < 2) ? 2 : d) + DR;
            dq.push_back(d);
            lq.push_back(b == nb - 1);
            if (b < nb - 1) begin
               cd = endc;
            end else begin
               mdl_db = ~mdl_db;
               exp_q.push_back('{EV_STP, endc, nb, t + 1, mdl_db, (t + 1 == neff)});
               if (t + 1 < neff) exp_q.push_back('{EV_CLR, endc + 1, 0, t + 1, mdl_db, 0});
               cd = endc + 2;
            end
         end
      end
      bus.i_num_timesteps = TSW'(nts);
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      for (int i = 0; i < dq.size(); i++) begin
         wait_dispatch(ok);
         if (!ok) return;
         d    = dq[i];
         kmax = (d < 2) ? 2 : d;
         inj  = ($urandom_range(0, 2) == 0);
         for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            // RUN cycle 1 carries stale all-ones; partial vectors until cycle d
            bus.i_done_batch_vec = (k == 1 || k >= d) ? '1 : partial_vec();
            bus.i_done_all_vec   = (lq[i] != 0 && k >= d) ? '1 : partial_vec();
            bus.i_start          = (k == 1 && inj);
            bus.i_num_timesteps  = TSW'($urandom_range(0, 9));
         end
         bus.i_start = 1'b0;
      end
      repeat (DR + 2) @(negedge clk);
      chk("end_busy", bus.o_busy, 0);
      chk("end_dispatch", bus.o_dispatch, 0);
      chk("end_timestep", bus.o_timestep, neff);
      chk("end_queue_empty", exp_q.size(), 0);
      bus.i_done_batch_vec = '0;
      bus.i_done_all_vec   = '0;
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $finish;
   end

   initial begin
      bit ok;
      int cd;
      bus.i_start          = 1'b0;
      bus.i_num_timesteps  = '0;
      bus.i_done_batch_vec = '0;
      bus.i_done_all_vec   = '0;

      // reset and idle
      repeat (3) @(negedge clk);
      chk("rst_dispatch", bus.o_dispatch, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_dbuf", bus.o_double_buffer, 0);
      chk("rst_timestep", bus.o_timestep, 0);
      chk("rst_batch_count", bus.o_batch_count, 0);
      chk("rst_pulses", {bus.o_step_done, bus.o_run_done, bus.o_err}, 0);
      reset = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("idle_busy", bus.o_busy, 0);
         chk("idle_dispatch", bus.o_dispatch, 0);
         chk("idle_timestep", bus.o_timestep, 0);
      end

      run_scen(1, 1, 0);   // single timestep, single batch
      run_scen(1, 3, 0);   // multi-batch
      run_scen(4, 1, 0);   // multi-timestep
      run_scen(0, 0, 0);   // zero count runs one timestep
      run_scen(2, 0, 52);  // long partial-done stretch
      for (int i = 0; i < 5; i++) run_scen($urandom_range(1, 3), 0, 0);

      // reset in the middle of RUN
      exp_q.push_back('{EV_CLR, cyc + 1, 0, 0, mdl_db, 0});
      exp_q.push_back('{EV_DSP, cyc + 2, 1, 0, mdl_db, 0});
      bus.i_num_timesteps = 16'd3;
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      wait_dispatch(ok);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      mdl_db = 1'b0;
      chk("midrst_busy", bus.o_busy, 0);
      chk("midrst_dispatch", bus.o_dispatch, 0);
      chk("midrst_pulses", {bus.o_step_done, bus.o_run_done}, 0);
      chk("midrst_dbuf", bus.o_double_buffer, 0);
      chk("midrst_timestep", bus.o_timestep, 0);
      chk("midrst_queue_empty", exp_q.size(), 0);
      reset = 1'b1;
      @(negedge clk);

      // done_batch never arrives
      exp_q.push_back('{EV_CLR, cyc + 1, 0, 0, mdl_db, 0});
      exp_q.push_back('{EV_DSP, cyc + 2, 1, 0, mdl_db, 0});
      bus.i_num_timesteps = 16'd1;
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      wait_dispatch(ok);
      cd = cyc;
`ifdef POSITION_RING_SCHED_WATCHDOG_EN
      // abort after RUN cycle TO: one dispatch=11 seen on the next cycle
      exp_q.push_back('{EV_CLR, cd + TO + 1, 1, 0, mdl_db, 0});
      repeat (TO + 2) @(negedge clk);
      chk("wd_err", bus.o_err, 1);
      chk("wd_busy", bus.o_busy, 0);
      chk("wd_dispatch", bus.o_dispatch, 0);
      chk("wd_queue_empty", exp_q.size(), 0);
`else
      repeat (3 * TO) @(negedge clk);
      chk("nowd_err", bus.o_err, 0);
      chk("nowd_busy", bus.o_busy, 1);
      chk("nowd_dispatch", bus.o_dispatch, 0);
      chk("nowd_queue_empty", exp_q.size(), 0);
      chk("nowd_cycles", cyc - cd, 3 * TO);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      mdl_db = 1'b0;
`endif
      @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
